// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit sitting between the EX/MEM and MEM/WB registers.
// Non-memory ops pass straight through. Memory ops are issued on a single-beat
// data bus (req/gnt address phase, rvalid data phase). Loads stall the pipe
// until their data returns.
//
// Build option: define MISALIGN_TRAP_EN to flag misaligned half/word accesses
// on misalign_o instead of silently aligning them down.

`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef ZeroWord
`define ZeroWord 32'h0000_0000
`endif
`ifndef ZeroReg
`define ZeroReg 5'h00
`endif

module mem_lsu (
  input  logic               clk,
  input  logic               rst,
  // EX/MEM side
  input  logic               valid_i,
  input  logic [`RegBus]     reg_wdata_i,
  input  logic               reg_we_i,
  input  logic [`RegAddrBus] reg_waddr_i,
  input  logic               mem_re_i,
  input  logic               mem_we_i,
  input  logic [2:0]         mem_funct3_i,
  input  logic [31:0]        mem_addr_i,
  input  logic [31:0]        mem_wdata_i,
  // MEM/WB side
  output logic [`RegBus]     reg_wdata_o,
  output logic               reg_we_o,
  output logic [`RegAddrBus] reg_waddr_o,
  output logic               stall_o,
  // Data bus
  output logic               dbus_req_o,
  output logic               dbus_we_o,
  output logic [31:0]        dbus_addr_o,
  output logic [3:0]         dbus_be_o,
  output logic [31:0]        dbus_wdata_o,
  input  logic               dbus_gnt_i,
  input  logic               dbus_rvalid_i,
  input  logic [31:0]        dbus_rdata_i
`ifdef MISALIGN_TRAP_EN
  ,
  output logic               misalign_o
`endif
);

  typedef enum logic [0:0] {
    StIdle,
    StWait
  } state_e;

  state_e state_q;

  logic       mem_op;
  logic       is_store;
  logic       is_byte;
  logic       is_half;
  logic       is_word;
  logic [1:0] lane;
  logic       trap;
  logic [3:0] st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Both enables set is treated as a store.
  assign mem_op   = valid_i & (mem_re_i | mem_we_i);
  assign is_store = mem_we_i;
  assign is_byte  = (mem_funct3_i[1:0] == 2'b00);
  assign is_half  = (mem_funct3_i[1:0] == 2'b01);
  assign is_word  = ~is_byte & ~is_half;

  // Byte lane of the access, forced to the natural alignment of its size.
  always_comb begin
    lane = mem_addr_i[1:0];
    if (is_word) begin
      lane = 2'b00;
    end else if (is_half) begin
      lane = {mem_addr_i[1], 1'b0};
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = (is_half & mem_addr_i[0]) | (is_word & (mem_addr_i[1:0] != 2'b00));
  assign trap       = mem_op & misaligned;
  assign misalign_o = ~rst & (state_q == StIdle) & trap;
`else
  assign trap = 1'b0;
`endif

  // Store byte enables and lane-replicated store data.
  always_comb begin
    st_be    = 4'b1111;
    st_wdata = mem_wdata_i;
    if (is_byte) begin
      st_be    = 4'b0001 << lane;
      st_wdata = {4{mem_wdata_i[7:0]}};
    end else if (is_half) begin
      st_be    = 4'b0011 << lane;
      st_wdata = {2{mem_wdata_i[15:0]}};
    end
  end

  // Load lane extraction and sign/zero extension (funct3[2] = unsigned).
  always_comb begin
    case (lane)
      2'b00:   ld_byte = dbus_rdata_i[7:0];
      2'b01:   ld_byte = dbus_rdata_i[15:8];
      2'b10:   ld_byte = dbus_rdata_i[23:16];
      default: ld_byte = dbus_rdata_i[31:24];
    endcase
    ld_half = lane[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    ld_data = dbus_rdata_i;
    if (is_byte) begin
      ld_data = mem_funct3_i[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end else if (is_half) begin
      ld_data = mem_funct3_i[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end
  end

  // Output decode: passthrough, bus request, stall and load write-back.
  always_comb begin
    reg_wdata_o  = reg_wdata_i;
    reg_waddr_o  = reg_waddr_i;
    reg_we_o     = 1'b0;
    stall_o      = 1'b0;
    dbus_req_o   = 1'b0;
    dbus_we_o    = 1'b0;
    dbus_addr_o  = {mem_addr_i[31:2], 2'b00};
    dbus_be_o    = is_store ? st_be : 4'b1111;
    dbus_wdata_o = st_wdata;
    if (rst) begin
      reg_wdata_o = `ZeroWord;
      reg_waddr_o = `ZeroReg;
    end else if (state_q == StWait) begin
      // Waiting for load data; a bubble goes to MEM/WB until it arrives.
      if (dbus_rvalid_i) begin
        reg_wdata_o = ld_data;
        reg_we_o    = reg_we_i;
      end else begin
        stall_o = 1'b1;
      end
    end else if (valid_i) begin
      if (!mem_op) begin
        reg_we_o = reg_we_i;
      end else if (!trap) begin
        dbus_req_o = 1'b1;
        dbus_we_o  = is_store;
        // Stores retire in their grant cycle; loads always continue into WAIT.
        stall_o    = is_store ? ~dbus_gnt_i : 1'b1;
      end
    end
  end

  // FSM: IDLE issues requests, WAIT holds a granted load until rvalid.
  // rvalid seen in IDLE (including the grant cycle) is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (mem_op && !is_store && !trap && dbus_gnt_i) begin
            state_q <= StWait;
          end
        end
        StWait: begin
          if (dbus_rvalid_i) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu. Inputs change 1ns after posedge; outputs
// are sampled on the falling edge. Build with MISALIGN_TRAP_EN to cover the
// trap variant.

module tb_mem_lsu;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [31:0] reg_wdata_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic        mem_re_i;
  logic        mem_we_i;
  logic [2:0]  mem_funct3_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] reg_wdata_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;
  logic        stall_o;
  logic        dbus_req_o;
  logic        dbus_we_o;
  logic [31:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        dbus_gnt_i;
  logic        dbus_rvalid_i;
  logic [31:0] dbus_rdata_i;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  mem_lsu dut (
    .clk           (clk),
    .rst           (rst),
    .valid_i       (valid_i),
    .reg_wdata_i   (reg_wdata_i),
    .reg_we_i      (reg_we_i),
    .reg_waddr_i   (reg_waddr_i),
    .mem_re_i      (mem_re_i),
    .mem_we_i      (mem_we_i),
    .mem_funct3_i  (mem_funct3_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .reg_wdata_o   (reg_wdata_o),
    .reg_we_o      (reg_we_o),
    .reg_waddr_o   (reg_waddr_o),
    .stall_o       (stall_o),
    .dbus_req_o    (dbus_req_o),
    .dbus_we_o     (dbus_we_o),
    .dbus_addr_o   (dbus_addr_o),
    .dbus_be_o     (dbus_be_o),
    .dbus_wdata_o  (dbus_wdata_o),
    .dbus_gnt_i    (dbus_gnt_i),
    .dbus_rvalid_i (dbus_rvalid_i),
    .dbus_rdata_i  (dbus_rdata_i)
`ifdef MISALIGN_TRAP_EN
    ,
    .misalign_o    (misalign_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    valid_i       = 1'b0;
    reg_we_i      = 1'b0;
    mem_re_i      = 1'b0;
    mem_we_i      = 1'b0;
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b0;
  endtask

  task automatic set_mem(input logic re, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata);
    valid_i      = 1'b1;
    reg_we_i     = 1'b1;
    reg_waddr_i  = 5'd9;
    reg_wdata_i  = 32'hCAFE_0000;
    mem_re_i     = re;
    mem_we_i     = we;
    mem_funct3_i = f3;
    mem_addr_i   = addr;
    mem_wdata_i  = wdata;
  endtask

  // Load granted immediately, data returned the following cycle.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [31:0] exp_addr,
                         input logic [31:0] exp);
    set_mem(1'b1, 1'b0, f3, addr, 32'h0);
    dbus_gnt_i = 1'b1;
    sample();
    check_eq({tag, "_addr"}, dbus_addr_o, exp_addr);
    check_eq({tag, "_stall"}, {31'h0, stall_o}, 32'h1);
    tick();
    dbus_gnt_i    = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = rdata;
    sample();
    check_eq({tag, "_data"}, reg_wdata_o, exp);
    check_eq({tag, "_we"}, {31'h0, reg_we_o}, 32'h1);
    tick();
    idle_inputs();
  endtask

  int stall_cnt;

  initial begin
    rst          = 1'b1;
    idle_inputs();
    reg_wdata_i  = 32'h55;
    reg_waddr_i  = 5'd3;
    mem_funct3_i = 3'b010;
    mem_addr_i   = 32'h0;
    mem_wdata_i  = 32'h0;
    dbus_rdata_i = 32'h0;
    // Reset forces outputs even with an active load presented.
    valid_i  = 1'b1;
    reg_we_i = 1'b1;
    mem_re_i = 1'b1;
    sample();
    check_eq("rst_req", {31'h0, dbus_req_o}, 32'h0);
    check_eq("rst_stall", {31'h0, stall_o}, 32'h0);
    check_eq("rst_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("rst_wdata", reg_wdata_o, 32'h0);
    check_eq("rst_waddr", {27'h0, reg_waddr_o}, 32'h0);
    tick();
    tick();
    rst = 1'b0;
    idle_inputs();

    // ADD passthrough
    valid_i     = 1'b1;
    reg_wdata_i = 32'h1234;
    reg_waddr_i = 5'd5;
    reg_we_i    = 1'b1;
    sample();
    check_eq("add_wdata", reg_wdata_o, 32'h1234);
    check_eq("add_waddr", {27'h0, reg_waddr_o}, 32'd5);
    check_eq("add_we", {31'h0, reg_we_o}, 32'h1);
    check_eq("add_stall", {31'h0, stall_o}, 32'h0);
    check_eq("add_req", {31'h0, dbus_req_o}, 32'h0);
    tick();

    // valid_i low: no write-back, stray rvalid in IDLE ignored
    valid_i       = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'hFFFF_FFFF;
    sample();
    check_eq("inv_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("inv_req", {31'h0, dbus_req_o}, 32'h0);
    check_eq("inv_stall", {31'h0, stall_o}, 32'h0);
    tick();
    dbus_rvalid_i = 1'b0;
    valid_i       = 1'b1;
    sample();
    check_eq("post_stray_we", {31'h0, reg_we_o}, 32'h1);
    check_eq("post_stray_wdata", reg_wdata_o, 32'h1234);
    tick();
    idle_inputs();

    // LB 0x103: gnt in cycle 2, rvalid in cycle 5 -> 5 stall cycles
    set_mem(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    reg_waddr_i  = 5'd7;
    dbus_rdata_i = 32'h80FF_FF00;
    stall_cnt    = 0;
    for (int k = 0; k < 6; k++) begin
      dbus_gnt_i    = (k == 2);
      dbus_rvalid_i = (k == 5);
      sample();
      if (k == 0) begin
        check_eq("lb_req", {31'h0, dbus_req_o}, 32'h1);
        check_eq("lb_addr", dbus_addr_o, 32'h100);
        check_eq("lb_be", {28'h0, dbus_be_o}, 32'hF);
      end
      if (k == 3) check_eq("lb_wait_req", {31'h0, dbus_req_o}, 32'h0);
      if (k < 5) begin
        if (stall_o) stall_cnt++;
        check_eq("lb_stall_we", {31'h0, reg_we_o}, 32'h0);
      end else begin
        check_eq("lb_stall_cnt", stall_cnt, 32'd5);
        check_eq("lb_end_stall", {31'h0, stall_o}, 32'h0);
        check_eq("lb_data", reg_wdata_o, 32'hFFFF_FF80);
        check_eq("lb_we", {31'h0, reg_we_o}, 32'h1);
        check_eq("lb_waddr", {27'h0, reg_waddr_o}, 32'd7);
      end
      tick();
    end
    idle_inputs();
    sample();
    check_eq("lb_we_once", {31'h0, reg_we_o}, 32'h0);
    tick();

    // SH 0x202 granted immediately
    set_mem(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD);
    dbus_gnt_i = 1'b1;
    sample();
    check_eq("sh_req", {31'h0, dbus_req_o}, 32'h1);
    check_eq("sh_dwe", {31'h0, dbus_we_o}, 32'h1);
    check_eq("sh_addr", dbus_addr_o, 32'h200);
    check_eq("sh_be", {28'h0, dbus_be_o}, 32'hC);
    check_eq("sh_wdata", dbus_wdata_o, 32'hABCD_ABCD);
    check_eq("sh_stall", {31'h0, stall_o}, 32'h0);
    check_eq("sh_we", {31'h0, reg_we_o}, 32'h0);
    tick();

    // SB 0x101 waits one cycle for grant
    set_mem(1'b0, 1'b1, 3'b000, 32'h101, 32'h1234_5678);
    dbus_gnt_i = 1'b0;
    sample();
    check_eq("sb_stall_nognt", {31'h0, stall_o}, 32'h1);
    check_eq("sb_be", {28'h0, dbus_be_o}, 32'h2);
    check_eq("sb_wdata", dbus_wdata_o, 32'h7878_7878);
    tick();
    dbus_gnt_i = 1'b1;
    sample();
    check_eq("sb_req_held", {31'h0, dbus_req_o}, 32'h1);
    check_eq("sb_stall_gnt", {31'h0, stall_o}, 32'h0);
    tick();

    // SW with both re and we set behaves as a store
    set_mem(1'b1, 1'b1, 3'b010, 32'h300, 32'hDEAD_BEEF);
    dbus_gnt_i = 1'b1;
    sample();
    check_eq("sw_dwe", {31'h0, dbus_we_o}, 32'h1);
    check_eq("sw_be", {28'h0, dbus_be_o}, 32'hF);
    check_eq("sw_wdata", dbus_wdata_o, 32'hDEAD_BEEF);
    check_eq("sw_stall", {31'h0, stall_o}, 32'h0);
    tick();
    // Still IDLE afterwards: a passthrough op is not stalled
    idle_inputs();
    valid_i  = 1'b1;
    reg_we_i = 1'b1;
    sample();
    check_eq("sw_after_stall", {31'h0, stall_o}, 32'h0);
    tick();
    idle_inputs();

    // LW 0x40 granted, reset in WAIT, rvalid after reset
    set_mem(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
    dbus_gnt_i = 1'b1;
    sample();
    tick();
    dbus_gnt_i = 1'b0;
    rst        = 1'b1;
    sample();
    check_eq("rstw_stall", {31'h0, stall_o}, 32'h0);
    check_eq("rstw_we", {31'h0, reg_we_o}, 32'h0);
    tick();
    rst           = 1'b0;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1111_2222;
    sample();
    check_eq("rstw_rv_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("rstw_idle_req", {31'h0, dbus_req_o}, 32'h1);
    tick();
    idle_inputs();

    // LHU 0x6: gnt with stray rvalid, real rvalid next cycle
    set_mem(1'b1, 1'b0, 3'b101, 32'h6, 32'h0);
    dbus_gnt_i    = 1'b1;
    dbus_rvalid_i = 1'b1;
    dbus_rdata_i  = 32'h1234_5678;
    sample();
    check_eq("lhu_gnt_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("lhu_gnt_stall", {31'h0, stall_o}, 32'h1);
    tick();
    dbus_gnt_i   = 1'b0;
    dbus_rdata_i = 32'h8001_0000;
    sample();
    check_eq("lhu_data", reg_wdata_o, 32'h0000_8001);
    check_eq("lhu_we", {31'h0, reg_we_o}, 32'h1);
    check_eq("lhu_stall", {31'h0, stall_o}, 32'h0);
    tick();
    idle_inputs();

    // Load extension table
    do_load("lb_pos", 3'b000, 32'h000, 32'h0000_007F, 32'h000, 32'h0000_007F);
    do_load("lb_l1", 3'b000, 32'h001, 32'h0000_F100, 32'h000, 32'hFFFF_FFF1);
    do_load("lbu", 3'b100, 32'h103, 32'h80FF_FF00, 32'h100, 32'h0000_0080);
    do_load("lh", 3'b001, 32'h002, 32'h8001_0000, 32'h000, 32'hFFFF_8001);
    do_load("lw", 3'b010, 32'h040, 32'hDEAD_BEEF, 32'h040, 32'hDEAD_BEEF);

`ifdef MISALIGN_TRAP_EN
    set_mem(1'b1, 1'b0, 3'b010, 32'h41, 32'h0);
    dbus_gnt_i = 1'b1;
    sample();
    check_eq("mis_flag", {31'h0, misalign_o}, 32'h1);
    check_eq("mis_req", {31'h0, dbus_req_o}, 32'h0);
    check_eq("mis_we", {31'h0, reg_we_o}, 32'h0);
    check_eq("mis_stall", {31'h0, stall_o}, 32'h0);
    tick();
    idle_inputs();
    sample();
    check_eq("mis_clear", {31'h0, misalign_o}, 32'h0);
    tick();
`else
    do_load("lw_mis", 3'b010, 32'h041, 32'hDEAD_BEEF, 32'h040, 32'hDEAD_BEEF);
    do_load("lh_mis", 3'b001, 32'h003, 32'h8001_0000, 32'h000, 32'hFFFF_8001);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  synchronous active-high reset.
REQ-002 SHALL have EX/MEM-side inputs: valid_i  in  1  instruction present; reg_wdata_i  in  `RegBus  ALU result; reg_we_i  in  1  write-back enable; reg_waddr_i  in  `RegAddrBus  destination; mem_re_i  in  1  load; mem_we_i  in  1  store; mem_funct3_i  in  3  access type; mem_addr_i  in  32  byte address; mem_wdata_i  in  32  store data.
REQ-003 SHALL have MEM/WB-side outputs: reg_wdata_o  out  `RegBus; reg_we_o  out  1; reg_waddr_o  out  `RegAddrBus; stall_o  out  1  freeze upstream stages.
REQ-004 SHALL have data-bus ports: dbus_req_o  out  1; dbus_we_o  out  1; dbus_addr_o  out  32  word-aligned; dbus_be_o  out  4; dbus_wdata_o  out  32; dbus_gnt_i  in  1; dbus_rvalid_i  in  1; dbus_rdata_i  in  32.

Function
REQ-005 SHALL implement FSM states IDLE and WAIT, held in a register.
REQ-006 Non-memory op (valid_i=1, mem_re_i=mem_we_i=0): outputs SHALL pass reg_* inputs through combinationally, stall_o=0, zero added latency.
REQ-007 valid_i=0: reg_we_o SHALL be 0, dbus_req_o 0, stall_o 0.
REQ-008 IDLE with memory op: dbus_req_o=1, dbus_we_o=mem_we_i, dbus_addr_o={mem_addr_i[31:2],2'b00}; request held every cycle until dbus_gnt_i=1.
REQ-009 Store: byte enables SB=0001<<addr[1:0], SH=0011<<addr[1:0], SW=1111; dbus_wdata_o = store data replicated across lanes (byte x4, half x2).
REQ-010 Store SHALL complete in the gnt cycle: stall_o=0 that cycle, FSM stays IDLE, reg_we_o=0 (stores do not write back).
REQ-011 Load: stall_o=1 in IDLE until gnt; on gnt FSM -> WAIT; dbus_be_o=1111 for loads.
REQ-012 WAIT: dbus_req_o=0, stall_o=1, reg_we_o=0 until dbus_rvalid_i=1.
REQ-013 WAIT with rvalid: reg_wdata_o = lane selected by mem_addr_i[1:0], extended per funct3 (LB/LH sign, LBU/LHU zero, LW raw); reg_we_o=reg_we_i; stall_o=0; FSM -> IDLE.
REQ-014 While stall_o=1, reg_we_o SHALL be 0 (bubble into MEM/WB); upstream holds EX/MEM inputs stable.
REQ-015 dbus_rvalid_i in IDLE SHALL be ignored.
REQ-016 gnt and rvalid in the same cycle for a load: only gnt acted on; rvalid counted from the following cycle.
REQ-017 mem_re_i and mem_we_i both 1: treated as store.

Reset
REQ-018 On rst at clock edge: FSM -> IDLE; abandons any outstanding load (reset mid-WAIT discards later rvalid per REQ-015).
REQ-019 While rst=1: dbus_req_o=0, stall_o=0, reg_we_o=0, reg_wdata_o=`ZeroWord, reg_waddr_o=`ZeroReg.

Configuration
REQ-020 Macro MISALIGN_TRAP_EN defined: half access with addr[0]=1 or word access with addr[1:0]!=0 SHALL assert output misalign_o (1 bit) for one cycle, issue no bus request, force reg_we_o=0, stall_o=0.
REQ-021 Macro undefined: no misalign_o port; misaligned accesses use addr with low bits forced to natural alignment (half: addr[0]=0, word: addr[1:0]=0).

Verification
REQ-022 ADD passthrough: valid_i=1, reg_wdata_i=0x1234, waddr=5, we=1 -> same-cycle reg_wdata_o=0x1234, reg_we_o=1, stall_o=0, no dbus_req_o.
REQ-023 LB addr=0x103, gnt after 2 cycles, rvalid 3 cycles later with rdata=0x80FF_FF00 -> stall_o=1 for 5 cycles, then reg_wdata_o=0xFFFF_FF80, reg_we_o=1 for one cycle.
REQ-024 SH addr=0x202, wdata=0xABCD, gnt immediate -> dbus_addr_o=0x200, dbus_be_o=1100, dbus_wdata_o=0xABCDABCD, stall_o=0 same cycle, reg_we_o=0.
REQ-025 LW addr=0x40 granted, rst asserted in WAIT, rvalid arrives after rst released -> FSM IDLE, reg_we_o stays 0, no write-back.
REQ-026 LHU addr=0x6, gnt and stray rvalid same cycle, rvalid next cycle rdata=0x8001_0000 -> second rvalid used, reg_wdata_o=0x0000_8001.
REQ-027 With MISALIGN_TRAP_EN: LW addr=0x41 -> misalign_o=1 one cycle, dbus_req_o=0, reg_we_o=0; without it -> access at 0x40.
